// File: rtl/i2c_tx_buffer_if.sv
// Bus between the transmit buffer and its environment: the host byte
// writer on one side and the I2C byte master on the other.
`timescale 1ns/1ps
interface i2c_tx_buffer_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             flush;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] e_bits;
  logic             m_start;
  logic             m_busy;
  logic             m_done;
  logic             ovf;

  // The buffer itself
  modport slave (
    input  wr_en, wr_data, flush, m_busy, m_done,
    output full, empty, count, e_bits, m_start, ovf
  );

  // Host writer plus I2C master driving the buffer
  modport master (
    output wr_en, wr_data, flush, m_busy, m_done,
    input  full, empty, count, e_bits, m_start, ovf
  );
endinterface

// File: rtl/i2c_tx_buffer.sv
// Transmit FIFO in front of an I2C byte master. The host pushes bytes; a
// small FSM pops one byte at a time, presents it on e_bits, pulses m_start
// and waits for the master to finish before fetching the next byte.
`timescale 1ns/1ps
module i2c_tx_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  i2c_tx_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             pop;
  logic             push;

  assign bus.full  = (count_q == CW'(DEPTH));
  assign bus.empty = (count_q == '0);
  assign bus.count = count_q;

  // LOAD only pops when a byte is really there; a flush racing the
  // IDLE->LOAD step can leave LOAD facing an empty FIFO.
  assign pop  = (state == LOAD) && !bus.empty;
  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign push = bus.wr_en && (!bus.full || pop);

  // Pointer/occupancy bookkeeping, flush clearing and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      bus.ovf <= 1'b0;
    end else begin
      if (bus.wr_en && bus.full && !pop) begin
        bus.ovf <= 1'b1;
      end
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Byte storage; contents are don't-care after reset or flush
  always_ff @(posedge clk) begin
    if (rst && push && !bus.flush) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Transfer sequencer with registered e_bits and one-cycle m_start
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      bus.e_bits  <= '0;
      bus.m_start <= 1'b0;
    end else begin
      bus.m_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.empty) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (pop) begin
            bus.e_bits  <= mem[rd_ptr];
            bus.m_start <= 1'b1;
            state       <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.m_done) begin
            state <= IDLE;
          end else if (bus.m_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.m_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_tx_buffer.sv
// Self-checking bench for i2c_tx_buffer: directed scenarios plus a
// randomised wrap run, checked against a queue-based model of the FIFO.
`timescale 1ns/1ps
module tb_i2c_tx_buffer;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  i2c_tx_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  i2c_tx_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Bytes seen on e_bits whenever m_start is high
  logic [7:0] rx_q [$];
  // Reference model: bytes waiting in the FIFO, bytes expected on the wire
  logic [7:0] pend_q [$];
  logic [7:0] exp_q [$];
  bit         model_ovf = 1'b0;

  // Master behaviour knobs
  int busy_gap    = 2;
  int done_gap    = 20;
  bit stall       = 1'b0;
  bit rand_master = 1'b0;

  // Record every byte the buffer launches
  always @(negedge clk) begin
    if (bus.m_start) begin
      rx_q.push_back(bus.e_bits);
    end
  end

  // I2C master model: busy some cycles after m_start, optional stall, then done
  initial begin : master_model
    bit fast;
    bus.m_busy = 1'b0;
    bus.m_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.m_start) begin
        fast = rand_master && ($urandom_range(0, 3) == 0);
        if (!fast) begin
          repeat (busy_gap) @(negedge clk);
          bus.m_busy = 1'b1;
          while (stall) @(negedge clk);
        end
        repeat (done_gap) @(negedge clk);
        bus.m_done = 1'b1;
        bus.m_busy = 1'b0;
        @(negedge clk);
        bus.m_done = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One host write lasting a single clock edge
  task automatic applyStimulus(input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_data = data;
    step(1);
    bus.wr_en   = 1'b0;
  endtask

  // Back-to-back writes first, first+1, ... recorded in the model
  task automatic writeBurst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = first + 8'(i);
      if (pend_q.size() < DEPTH) pend_q.push_back(first + 8'(i));
      else model_ovf = 1'b1;
      step(1);
    end
    bus.wr_en = 1'b0;
  endtask

  // The oldest pending byte has been handed to the master
  function automatic void modelLaunch();
    if (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
  endfunction

  task automatic waitRx(input int n, input int limit, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < limit) begin
      step(1);
      k++;
    end
    checkOutput(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  // Let everything pending drain, then compare the wire against the model
  task automatic drainAndCompare(input string tag);
    while (pend_q.size() > 0) modelLaunch();
    waitRx(exp_q.size(), 400, {tag, "_drain"});
    step(30);
    checkOutput({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checkOutput({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    end
    checkOutput({tag, "_count"}, 32'(bus.count), 32'd0);
    checkOutput({tag, "_empty"}, 32'(bus.empty), 32'd1);
    checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'(model_ovf));
  endtask

  // Start a stalled transfer of one lead byte so the FSM parks in WAIT_DONE
  task automatic parkLead(input logic [7:0] lead, input string tag);
    stall = 1'b1;
    pend_q.push_back(lead);
    applyStimulus(lead);
    waitRx(1, 20, {tag, "_lead_start"});
    modelLaunch();
    step(6);
  endtask

  task automatic newScenario();
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.flush   = 1'b0;

    // Reset values
    rst = 1'b0;
    step(3);
    checkOutput("rst_m_start", 32'(bus.m_start), 32'd0);
    checkOutput("rst_e_bits", 32'(bus.e_bits), 32'd0);
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b1;
    step(2);

    // Single byte with write-to-start latency
    newScenario();
    busy_gap = 2;
    done_gap = 20;
    pend_q.push_back(8'hAA);
    applyStimulus(8'hAA);
    checkOutput("single_count1", 32'(bus.count), 32'd1);
    checkOutput("single_start_e0", 32'(bus.m_start), 32'd0);
    step(1);
    checkOutput("single_start_e1", 32'(bus.m_start), 32'd0);
    step(1);
    checkOutput("single_start_e2", 32'(bus.m_start), 32'd1);
    checkOutput("single_e_bits", 32'(bus.e_bits), 32'hAA);
    step(1);
    checkOutput("single_start_e3", 32'(bus.m_start), 32'd0);
    step(12);
    checkOutput("single_e_bits_held", 32'(bus.e_bits), 32'hAA);
    drainAndCompare("single");

    // Burst to full behind a stalled transfer, then overflow
    newScenario();
    busy_gap = 1;
    done_gap = 3;
    parkLead(8'h5A, "burst");
    checkOutput("burst_count0", 32'(bus.count), 32'd0);
    writeBurst(8'h01, 8);
    checkOutput("burst_full", 32'(bus.full), 32'd1);
    checkOutput("burst_count8", 32'(bus.count), 32'(pend_q.size()));
    checkOutput("burst_ovf_before", 32'(bus.ovf), 32'd0);
    writeBurst(8'hFF, 1);
    checkOutput("ovf_set", 32'(bus.ovf), 32'(model_ovf));
    checkOutput("ovf_count", 32'(bus.count), 32'(pend_q.size()));
    checkOutput("burst_e_bits_held", 32'(bus.e_bits), 32'h5A);
    stall = 1'b0;
    drainAndCompare("burst");

    // Randomised traffic across pointer wrap with a continuous master
    newScenario();
    rand_master = 1'b1;
    busy_gap = $urandom_range(0, 2);
    done_gap = $urandom_range(1, 4);
    for (int i = 0; i < 20; i++) begin
      int k;
      logic [7:0] b;
      step($urandom_range(0, 3));
      k = 0;
      while (bus.full && k < 200) begin
        step(1);
        k++;
      end
      checkOutput("wrap_room", 32'(bus.full), 32'd0);
      b = 8'($urandom);
      exp_q.push_back(b);
      applyStimulus(b);
    end
    drainAndCompare("wrap");
    rand_master = 1'b0;

    // Flush with three queued while a transfer is in flight
    newScenario();
    busy_gap = 1;
    done_gap = 3;
    parkLead(8'h77, "flush");
    writeBurst(8'h11, 3);
    checkOutput("flush_count3", 32'(bus.count), 32'd3);
    bus.flush   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h44;
    step(1);
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    pend_q.delete();
    checkOutput("flush_count0", 32'(bus.count), 32'd0);
    checkOutput("flush_empty", 32'(bus.empty), 32'd1);
    checkOutput("flush_e_bits", 32'(bus.e_bits), 32'h77);
    stall = 1'b0;
    drainAndCompare("flush");

    // Reset while parked in WAIT_DONE with four queued
    newScenario();
    parkLead(8'h99, "rstx");
    writeBurst(8'h21, 4);
    checkOutput("rstx_count4", 32'(bus.count), 32'd4);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    pend_q.delete();
    model_ovf = 1'b0;
    checkOutput("rstx_m_start", 32'(bus.m_start), 32'd0);
    checkOutput("rstx_e_bits", 32'(bus.e_bits), 32'd0);
    checkOutput("rstx_count", 32'(bus.count), 32'd0);
    checkOutput("rstx_full", 32'(bus.full), 32'd0);
    checkOutput("rstx_empty", 32'(bus.empty), 32'd1);
    checkOutput("rstx_ovf", 32'(bus.ovf), 32'd0);
    stall = 1'b0;
    step(40);
    checkOutput("rstx_no_start", 32'(rx_q.size()), 32'd1);
    pend_q.push_back(8'hC3);
    applyStimulus(8'hC3);
    step(2);
    checkOutput("rstx_new_start", 32'(bus.m_start), 32'd1);
    checkOutput("rstx_new_e_bits", 32'(bus.e_bits), 32'hC3);
    drainAndCompare("rstx");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
